// File: rtl/uart_tx_if.sv
// Byte-request / serial-line bundle between user logic and the UART transmitter.
interface uart_tx_if;
    logic       start;
    logic [7:0] din;
    logic       txd;
    logic       busy;
    logic       done;

    modport master (output start, output din, input txd, input busy, input done);
    modport slave  (input start, input din, output txd, output busy, output done);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: one byte per accepted start, framed as start, D0..D7, optional parity, stop bit(s).
module uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 5208,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    uart_tx_if.slave   bus
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] BAUD_PRE  = CW'(CLKS_PER_BIT - 2);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic          ODD_BIT   = 1'(PARITY_ODD);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    data_q, data_d;
    logic          txd_q, txd_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic          baud_wrap;
    logic          baud_pre;
    logic [2:0]    idx_inc;
    logic [CW-1:0] baud_inc;

    assign baud_wrap = (baud_q == BAUD_LAST);
    assign baud_pre  = (baud_q == BAUD_PRE);
    assign idx_inc   = idx_q + 3'd1;
    assign baud_inc  = baud_q + CW'(1);

    // State and registered outputs; txd idles high straight out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic; txd/busy/done are computed one edge ahead so they leave registers.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        idx_d   = idx_q;
        data_d  = data_q;
        txd_d   = txd_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                txd_d  = 1'b1;
                busy_d = 1'b0;
                baud_d = '0;
                if (bus.start) begin
                    data_d  = bus.din;
                    idx_d   = '0;
                    state_d = S_START;
                    txd_d   = 1'b0;
                    busy_d  = 1'b1;
                end
            end

            S_START: begin
                baud_d = baud_wrap ? '0 : baud_inc;
                if (baud_wrap) begin
                    state_d = S_DATA;
                    idx_d   = '0;
                    txd_d   = data_q[0];
                end
            end

            S_DATA: begin
                baud_d = baud_wrap ? '0 : baud_inc;
                if (baud_wrap) begin
                    if (idx_q == 3'd7) begin
                        idx_d = '0;
                        if (PARITY_EN != 0) begin
                            state_d = S_PARITY;
                            txd_d   = (^data_q) ^ ODD_BIT;
                        end else begin
                            state_d = S_STOP;
                            txd_d   = 1'b1;
                        end
                    end else begin
                        idx_d = idx_inc;
                        txd_d = data_q[idx_inc];
                    end
                end
            end

            S_PARITY: begin
                baud_d = baud_wrap ? '0 : baud_inc;
                if (baud_wrap) begin
                    state_d = S_STOP;
                    idx_d   = '0;
                    txd_d   = 1'b1;
                end
            end

            S_STOP: begin
                baud_d = baud_wrap ? '0 : baud_inc;
                txd_d  = 1'b1;
                // done is raised on the edge that enters the final cycle of the last stop bit
                if (idx_q == STOP_LAST && baud_pre) begin
                    done_d = 1'b1;
                end
                if (baud_wrap) begin
                    if (idx_q == STOP_LAST) begin
                        state_d = S_IDLE;
                        idx_d   = '0;
                        busy_d  = 1'b0;
                    end else begin
                        idx_d = idx_inc;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                txd_d   = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign bus.txd  = txd_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Four transmitter configurations driven by a shared byte/start stream and checked
// cycle by cycle against a frame-level reference model.
module tb_uart_tx;

    localparam int CPB = 4;
    localparam int NI  = 4;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] din;

    int pen   [NI] = '{0, 1, 1, 0};
    int podd  [NI] = '{0, 0, 1, 0};
    int nstop [NI] = '{1, 1, 2, 2};

    uart_tx_if if0 ();
    uart_tx_if if1 ();
    uart_tx_if if2 ();
    uart_tx_if if3 ();

    assign if0.start = start;  assign if0.din = din;
    assign if1.start = start;  assign if1.din = din;
    assign if2.start = start;  assign if2.din = din;
    assign if3.start = start;  assign if3.din = din;

    uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
        dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1))
        dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
    uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2))
        dut2 (.clk(clk), .rst(rst), .bus(if2.slave));
    uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2))
        dut3 (.clk(clk), .rst(rst), .bus(if3.slave));

    logic txd_w [NI];
    logic busy_w[NI];
    logic done_w[NI];
    assign txd_w[0] = if0.txd;  assign busy_w[0] = if0.busy;  assign done_w[0] = if0.done;
    assign txd_w[1] = if1.txd;  assign busy_w[1] = if1.busy;  assign done_w[1] = if1.done;
    assign txd_w[2] = if2.txd;  assign busy_w[2] = if2.busy;  assign done_w[2] = if2.done;
    assign txd_w[3] = if3.txd;  assign busy_w[3] = if3.busy;  assign done_w[3] = if3.done;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int frame_len(input int k);
        return (1 + 8 + pen[k] + nstop[k]) * CPB;
    endfunction

    // One bit per slot: slot 0 start, slots 1..8 data, then parity and/or stop slots.
    function automatic logic [11:0] build_frame(input logic [7:0] d, input int k);
        logic [11:0] f;
        f    = '1;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = d[i];
        if (pen[k] != 0) f[9] = (^d) ^ (podd[k] != 0);
        return f;
    endfunction

    // Reference model: a frame in flight is just (bit pattern, cycle offset).
    logic        m_active[NI] = '{default: 1'b0};
    int          m_cyc   [NI] = '{default: 0};
    logic [11:0] m_frame [NI] = '{default: '1};

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            m_active[k] = 1'b0;
            m_cyc[k]    = 0;
        end
    endtask

    always @(posedge clk) begin
        if (!rst) begin
            model_reset();
        end else begin
            for (int k = 0; k < NI; k++) begin
                if (m_active[k]) begin
                    if (m_cyc[k] == frame_len(k) - 1) m_active[k] = 1'b0;
                    else m_cyc[k] = m_cyc[k] + 1;
                end else if (start) begin
                    m_active[k] = 1'b1;
                    m_cyc[k]    = 0;
                    m_frame[k]  = build_frame(din, k);
                end
            end
        end
    end

    // Per-frame measurements used by the directed scenarios.
    int   busy_cnt[NI];
    int   done_cnt[NI];
    int   done_at [NI];
    logic txd_log [NI][64];

    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            logic exp_txd;
            logic exp_done;
            exp_txd  = m_active[k] ? m_frame[k][m_cyc[k] / CPB] : 1'b1;
            exp_done = m_active[k] && (m_cyc[k] == frame_len(k) - 1);
            check($sformatf("txd%0d", k),  32'(txd_w[k]),  32'(exp_txd));
            check($sformatf("busy%0d", k), 32'(busy_w[k]), 32'(m_active[k]));
            check($sformatf("done%0d", k), 32'(done_w[k]), 32'(exp_done));
            if (busy_w[k] === 1'b1) begin
                if (busy_cnt[k] < 64) txd_log[k][busy_cnt[k]] = txd_w[k];
                busy_cnt[k] = busy_cnt[k] + 1;
            end
            if (done_w[k] === 1'b1) begin
                done_cnt[k] = done_cnt[k] + 1;
                done_at[k]  = busy_cnt[k];
            end
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_meas();
        for (int k = 0; k < NI; k++) begin
            busy_cnt[k] = 0;
            done_cnt[k] = 0;
            done_at[k]  = -1;
        end
    endtask

    // One-cycle start with byte d; optionally a second start with mid_d at cycle mid.
    task automatic run_frame(input logic [7:0] d, input int mid, input logic [7:0] mid_d);
        step();
        clear_meas();
        start = 1'b1;
        din   = d;
        step();
        start = 1'b0;
        for (int c = 0; c < 56; c++) begin
            din = 8'($urandom);
            if (c == mid) begin
                start = 1'b1;
                din   = mid_d;
            end else begin
                start = 1'b0;
            end
            step();
        end
        start = 1'b0;
        for (int k = 0; k < NI; k++) begin
            check($sformatf("len%0d", k),    32'(busy_cnt[k]), 32'(frame_len(k)));
            check($sformatf("doneat%0d", k), 32'(done_at[k]),  32'(frame_len(k)));
            check($sformatf("ndone%0d", k),  32'(done_cnt[k]), 32'd1);
        end
    endtask

    task automatic check_a5_slots();
        logic [9:0] exp_slots;
        exp_slots = 10'b1101001010;
        for (int s = 0; s < 10; s++)
            for (int j = 0; j < CPB; j++)
                check($sformatf("a5slot%0d", s), 32'(txd_log[0][CPB*s + j]), 32'(exp_slots[s]));
    endtask

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        din   = 8'h00;
        clear_meas();
        repeat (2) step();
        check("rst_txd",  32'(if0.txd),  32'd1);
        check("rst_busy", 32'(if0.busy), 32'd0);
        check("rst_done", 32'(if0.done), 32'd0);
        rst = 1'b1;
        repeat (3) step();

        // Basic frame, all four configurations
        run_frame(8'hA5, -1, 8'h00);
        check_a5_slots();

        // Parity even/odd on 0x07
        run_frame(8'h07, -1, 8'h00);
        check("par_even", 32'(txd_log[1][CPB*9 + 1]), 32'd1);
        check("par_odd",  32'(txd_log[2][CPB*9 + 1]), 32'd0);

        // Two stop bits on 0xFF
        run_frame(8'hFF, -1, 8'h00);
        for (int i = CPB*9; i < CPB*11; i++)
            check("stop2", 32'(txd_log[3][i]), 32'd1);

        // Start during a frame with a different byte is ignored
        run_frame(8'hA5, 10, 8'h3C);
        check_a5_slots();

        // Start held high: back-to-back frames, gaps checked by the model
        step();
        start = 1'b1;
        din   = 8'h55;
        repeat (150) step();
        start = 1'b0;
        repeat (60) step();

        // Asynchronous reset in data bit 3
        step();
        start = 1'b1;
        din   = 8'($urandom);
        step();
        start = 1'b0;
        repeat (17) step();
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check("arst_txd0",  32'(if0.txd),  32'd1);
        check("arst_busy0", 32'(if0.busy), 32'd0);
        check("arst_done0", 32'(if0.done), 32'd0);
        check("arst_txd2",  32'(if2.txd),  32'd1);
        check("arst_busy2", 32'(if2.busy), 32'd0);
        check("arst_txd3",  32'(if3.txd),  32'd1);
        repeat (2) step();
        rst = 1'b1;
        repeat (2) step();
        run_frame(8'($urandom), -1, 8'h00);

        // Random starts and bytes
        for (int c = 0; c < 500; c++) begin
            start = ($urandom_range(0, 5) == 0);
            din   = 8'($urandom);
            step();
        end
        start = 1'b0;
        repeat (60) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
